// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 responder that mimics the ADXL362 register interface: ID/sample reads,
// configuration writes, coherent sample snapshots and a soft-reset command.
module adxl362_spi_responder #(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter logic [7:0] REVID       = 8'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    input  logic [11:0] accel_x,
    input  logic [11:0] accel_y,
    input  logic [11:0] accel_z,
    input  logic [11:0] temp,
    input  logic        sample_valid,
    output logic [7:0]  filter_ctl,
    output logic [7:0]  power_ctl,
    output logic        reg_wr,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy,
    output logic        cmd_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_IGN  = 3'd5;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   rise_d_reg;
    logic                   fall_d_reg;

    logic [2:0] state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_in_reg;
    logic       wr_flag_reg;
    logic [5:0] ptr_reg;
    logic [7:0] miso_sh_reg;
    logic       miso_reg;
    logic       reg_wr_reg;
    logic [5:0] reg_wr_addr_reg;
    logic [7:0] reg_wr_data_reg;
    logic       cmd_err_reg;

    logic [7:0]  cfg_reg [0:14];
    logic [11:0] sample_in [0:3];
    logic [11:0] snap_reg [0:3];
    logic [11:0] pend_reg [0:3];
    logic        pend_flag_reg;
    logic        data_ready_reg;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_rise;
    logic       ss_fall;
    logic       evt_ok;
    logic       shifting;
    logic       byte_done;
    logic       wr_commit;
    logic       soft_rst;
    logic       rd_load;
    logic [7:0] byte_full;
    logic [7:0] rd_byte;
    logic       dr_set;
    logic       dr_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_reg <= '0;
            ss_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            rise_d_reg    <= 1'b0;
            fall_d_reg    <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            rise_d_reg    <= sclk_rise;
            fall_d_reg    <= sclk_fall;
        end
    end

    // sclk edges are registered once more so the bit, commit and miso updates land
    // SYNC_STAGES+1 cycles after the pin edge; ss edges act one cycle earlier.
    assign sclk_rise = sclk_sync_reg[SYNC_STAGES-2] & ~sclk_sync_reg[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_sync_reg[SYNC_STAGES-2] & sclk_sync_reg[SYNC_STAGES-1];
    assign ss_rise   = ss_sync_reg[SYNC_STAGES-2] & ~ss_sync_reg[SYNC_STAGES-1];
    assign ss_fall   = ~ss_sync_reg[SYNC_STAGES-2] & ss_sync_reg[SYNC_STAGES-1];
    assign busy      = ~ss_sync_reg[SYNC_STAGES-1];

    assign evt_ok    = !ss_rise && !ss_fall;
    assign shifting  = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                       (state_reg == ST_WR)  || (state_reg == ST_RD);
    assign byte_full = {shift_in_reg[6:0], mosi_sync_reg[SYNC_STAGES-1]};
    assign byte_done = evt_ok && rise_d_reg && shifting && (bit_cnt_reg == 3'd7);
    assign wr_commit = byte_done && (state_reg == ST_WR);
    assign soft_rst  = wr_commit && (ptr_reg == 6'h1F) && (byte_full == 8'h52);
    assign rd_load   = evt_ok && fall_d_reg && (state_reg == ST_RD) && (bit_cnt_reg == 3'd0);

    always_comb begin
        rd_byte = 8'h00;
        case (ptr_reg)
            6'h00: rd_byte = DEVID_AD;
            6'h01: rd_byte = DEVID_MST;
            6'h02: rd_byte = PARTID;
            6'h03: rd_byte = REVID;
            6'h08: rd_byte = snap_reg[0][11:4];
            6'h09: rd_byte = snap_reg[1][11:4];
            6'h0A: rd_byte = snap_reg[2][11:4];
            6'h0B: rd_byte = {7'b0, data_ready_reg};
            6'h0E: rd_byte = snap_reg[0][7:0];
            6'h0F: rd_byte = {{4{snap_reg[0][11]}}, snap_reg[0][11:8]};
            6'h10: rd_byte = snap_reg[1][7:0];
            6'h11: rd_byte = {{4{snap_reg[1][11]}}, snap_reg[1][11:8]};
            6'h12: rd_byte = snap_reg[2][7:0];
            6'h13: rd_byte = {{4{snap_reg[2][11]}}, snap_reg[2][11:8]};
            6'h14: rd_byte = snap_reg[3][7:0];
            6'h15: rd_byte = {{4{snap_reg[3][11]}}, snap_reg[3][11:8]};
            default: begin
                if (ptr_reg >= 6'h20 && ptr_reg <= 6'h2E) begin
                    rd_byte = cfg_reg[ptr_reg[3:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_in_reg    <= 8'h00;
            wr_flag_reg     <= 1'b0;
            ptr_reg         <= 6'd0;
            miso_sh_reg     <= 8'h00;
            miso_reg        <= 1'b0;
            reg_wr_reg      <= 1'b0;
            reg_wr_addr_reg <= 6'd0;
            reg_wr_data_reg <= 8'h00;
            cmd_err_reg     <= 1'b0;
        end else begin
            reg_wr_reg  <= 1'b0;
            cmd_err_reg <= 1'b0;
            if (ss_rise) begin
                state_reg <= ST_IDLE;
                miso_reg  <= 1'b0;
            end else if (ss_fall) begin
                state_reg   <= ST_CMD;
                bit_cnt_reg <= 3'd0;
            end else begin
                if (rise_d_reg && shifting) begin
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                    shift_in_reg <= byte_full;
                end
                if (byte_done) begin
                    case (state_reg)
                        ST_CMD: begin
                            if (byte_full == 8'h0A) begin
                                wr_flag_reg <= 1'b1;
                                state_reg   <= ST_ADDR;
                            end else if (byte_full == 8'h0B) begin
                                wr_flag_reg <= 1'b0;
                                state_reg   <= ST_ADDR;
                            end else begin
                                cmd_err_reg <= 1'b1;
                                state_reg   <= ST_IGN;
                            end
                        end
                        ST_ADDR: begin
                            ptr_reg   <= byte_full[5:0];
                            state_reg <= wr_flag_reg ? ST_WR : ST_RD;
                        end
                        ST_WR: begin
                            reg_wr_reg      <= 1'b1;
                            reg_wr_addr_reg <= ptr_reg;
                            reg_wr_data_reg <= byte_full;
                            ptr_reg         <= ptr_reg + 6'd1;
                        end
                        default: ;
                    endcase
                end
                // Reload at the last fall of each byte so the MSB leads the next byte.
                if (rd_load) begin
                    miso_sh_reg <= rd_byte;
                    miso_reg    <= rd_byte[7];
                    ptr_reg     <= ptr_reg + 6'd1;
                end else if (evt_ok && fall_d_reg && state_reg == ST_RD) begin
                    miso_sh_reg <= {miso_sh_reg[6:0], 1'b0};
                    miso_reg    <= miso_sh_reg[6];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_cfg
            localparam logic [7:0] RST_VAL  = (gi == 12) ? 8'h13 : 8'h00;
            localparam logic [5:0] REG_ADDR = 6'h20 + 6'(gi);
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cfg_reg[gi] <= RST_VAL;
                end else if (soft_rst) begin
                    cfg_reg[gi] <= RST_VAL;
                end else if (wr_commit && ptr_reg == REG_ADDR) begin
                    cfg_reg[gi] <= byte_full;
                end
            end
        end
    endgenerate

    assign sample_in[0] = accel_x;
    assign sample_in[1] = accel_y;
    assign sample_in[2] = accel_z;
    assign sample_in[3] = temp;

    // A strobe arriving on the ss-rise cycle is newer than the pending buffer.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sample
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    snap_reg[gi] <= 12'd0;
                    pend_reg[gi] <= 12'd0;
                end else if (ss_rise && (pend_flag_reg || sample_valid)) begin
                    snap_reg[gi] <= sample_valid ? sample_in[gi] : pend_reg[gi];
                end else if (sample_valid) begin
                    if (busy) begin
                        pend_reg[gi] <= sample_in[gi];
                    end else begin
                        snap_reg[gi] <= sample_in[gi];
                    end
                end
            end
        end
    endgenerate

    assign dr_set = (sample_valid && !busy) || (ss_rise && (pend_flag_reg || sample_valid));
    assign dr_clr = rd_load && (ptr_reg >= 6'h08) && (ptr_reg <= 6'h15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_flag_reg  <= 1'b0;
            data_ready_reg <= 1'b0;
        end else begin
            if (ss_rise) begin
                pend_flag_reg <= 1'b0;
            end else if (sample_valid && busy) begin
                pend_flag_reg <= 1'b1;
            end
            data_ready_reg <= dr_set || (data_ready_reg && !dr_clr);
        end
    end

    assign miso        = miso_reg;
    assign reg_wr      = reg_wr_reg;
    assign reg_wr_addr = reg_wr_addr_reg;
    assign reg_wr_data = reg_wr_data_reg;
    assign cmd_err     = cmd_err_reg;
    assign filter_ctl  = cfg_reg[12];
    assign power_ctl   = cfg_reg[13];

endmodule

// File: doc/adxl362_spi_responder.md
# adxl362_spi_responder

Synthesizable SPI responder that models the ADXL362 accelerometer's serial register interface: the other end of the on-board accelerometer link driven by `AccelerometerCtl`. It decodes the register-read and register-write commands, serves a register map that holds a snapshot of externally supplied X/Y/Z/temperature samples, and stores the writable configuration registers. It is used in place of the physical sensor for closed-loop simulation and for on-board loopback through a Pmod header, so the ball/threshold logic can be exercised with scripted accelerations.

## Interface
- `DEVID_AD`, 8'hAD, value at address 0x00
- `DEVID_MST`, 8'h1D, value at address 0x01
- `PARTID`, 8'hF2, value at address 0x02
- `REVID`, 8'h01, value at address 0x03
- `SYNC_STAGES`, 2, synchronizer depth on `sclk`/`ss`/`mosi` (≥2)

- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`
- `ss`  in  1  chip select, active low
- `mosi`  in  1  serial data in, MSB first
- `miso`  out  1  serial data out, MSB first
- `accel_x`, `accel_y`, `accel_z`, `temp`  in  12 each  two's-complement sample
- `sample_valid`  in  1  one-cycle strobe; qualifies all four sample inputs
- `filter_ctl`  out  8  contents of register 0x2C
- `power_ctl`  out  8  contents of register 0x2D
- `reg_wr`  out  1  one-cycle pulse per committed write byte
- `reg_wr_addr`  out  6  address of the committed write
- `reg_wr_data`  out  8  data of the committed write
- `busy`  out  1  synchronized `ss` asserted
- `cmd_err`  out  1  one-cycle pulse when the command byte is unsupported

## Operation
- `sclk`, `ss`, and `mosi` each pass through a `SYNC_STAGES` synchronizer. Rise and fall of `sclk` are detected from the last two stages.
- Sample `mosi` on a detected `sclk` rise. Shift `miso` on a detected `sclk` fall.
- FSM states:
  - IDLE: `ss` high. Falling `ss` clears the bit counter and enters CMD.
  - CMD: collect 8 bits.
    - 0x0A enters ADDR with the write flag set.
    - 0x0B enters ADDR with the read flag set.
    - Any other value pulses `cmd_err` and enters IGNORE.
  - ADDR: collect 8 bits. The address pointer takes the low 6 bits. Then enter WR or RD.
  - WR: each completed byte commits to the pointer address, pulses `reg_wr`, and increments the pointer.
  - RD: the shift register loads the pointer address on the final `sclk` fall of the previous byte, then the pointer increments. The MSB is therefore on `miso` before the first rise of each data byte.
  - IGNORE: hold until `ss` rises.
- Rising `ss` in any state returns the FSM to IDLE.
- The address pointer wraps from 0x3F to 0x00.
- Register map:
  - 0x00–0x03: ID parameters.
  - 0x08, 0x09, 0x0A: X, Y, Z bits [11:4].
  - 0x0B: STATUS, `{7'b0, data_ready}`.
  - 0x0E/0x0F, 0x10/0x11, 0x12/0x13, 0x14/0x15: X, Y, Z, TEMP as low/high pairs.
    - Low byte = sample[7:0].
    - High byte = `{4{sample[11]}}, sample[11:8]`.
  - 0x1F: SOFT_RESET, write-only, reads 0x00.
  - 0x20–0x2E: read/write storage.
  - All other addresses read 0x00 and ignore writes.
- Writes to read-only addresses still pulse `reg_wr` but change nothing.
- Writing 0x52 to 0x1F restores 0x20–0x2E to reset values. It does not touch the sample snapshot.
- Sample coherency:
  - While `busy`=0, `sample_valid` loads the snapshot directly and sets `data_ready`.
  - While `busy`=1, the strobe loads a pending buffer and sets a pending flag.
  - On `ss` rise with the pending flag set, the pending buffer moves to the snapshot and sets `data_ready`.
  - A later strobe overwrites the pending buffer (latest wins).
- `data_ready` clears when any byte at 0x08–0x15 is read. If a set and a clear land in the same cycle, set wins.
- `miso` is 0 outside RD.

## Timing
- Reset values:
  - `miso`, `reg_wr`, `reg_wr_addr`, `reg_wr_data`, `busy`, `cmd_err` = 0.
  - `power_ctl` = 0x00; `filter_ctl` = 0x13.
  - 0x20–0x2E = 0x00 except 0x2C = 0x13.
  - Snapshot = 0; `data_ready` = 0; FSM in IDLE.
- The `sclk` high and low times must each be at least `SYNC_STAGES`+2 `clk` cycles: 12.5 MHz max at defaults.
- `ss` falling to the first `sclk` rise must be at least `SYNC_STAGES`+2 cycles.
- Write commit: `reg_wr` and the register update happen `SYNC_STAGES`+1 cycles after the 8th `sclk` rise of a data byte. `power_ctl`/`filter_ctl` change in that same cycle.
- `miso` changes `SYNC_STAGES`+1 cycles after an `sclk` fall.
- `busy` follows `ss` with `SYNC_STAGES` cycles of latency.
- `ss` rising mid-byte: the partial byte is discarded, with no write and no pointer change.
- `reset` asserted mid-transaction: immediate return to reset values. The transaction is not resumed; the master must reissue `ss`.

## Test plan
- Read IDs: `ss` low, send 0x0B, 0x00, then 4 dummy bytes → `miso` bytes 0xAD, 0x1D, 0xF2, 0x01; `cmd_err`=0.
- Write then read back:
  - Write 0x0A, 0x2D, 0x02 → `reg_wr` pulse with addr 0x2D, data 0x02; `power_ctl`=0x02.
  - Then read 0x0B, 0x2D → 0x02.
- Sample coherency:
  - `sample_valid` with X=0x8A5 while `busy`=0.
  - Start a burst read at 0x0E; mid-burst strobe X=0x123.
  - Burst returns 0xA5 then 0xF8.
  - After `ss` rises, read 0x0E returns 0x23; `data_ready` is set, then clears after the read.
- Abort: `ss` rises after 5 bits of a write data byte to 0x20 → no `reg_wr`; 0x20 stays 0x00.
- Unknown command 0x0D → one `cmd_err` pulse; `miso` stays 0 until `ss` rises; the next transaction works normally.
- Wrap and soft reset:
  - Burst read from 0x3F → bytes at 0x3F then 0x00, i.e. 0x00 then 0xAD.
  - Write 0x52 to 0x1F → `filter_ctl` returns to 0x13 and `power_ctl` to 0x00.
